siso_shift_controller: RTL and testbench

//  Sequencer for one 8-bit SISO shift register. Accepts parallel words on a valid/ready port and

---
 rtl/siso_ctrl_pkg.sv | 20 ++
 rtl/siso_shift_tick_gen.sv | 49 ++++
 rtl/siso_shift_controller.sv | 201 ++++++++++++++++++++
 tb/tb_siso_shift_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_ctrl_pkg.sv
// Shared types and default sizes for the SISO shift-register sequencer.
package siso_ctrl_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CHAIN_LENGTH = 8;
  localparam int DEF_DIV_WIDTH    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE,
    ST_CLEAR
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/siso_shift_tick_gen.sv
// Spacing generator for shift pulses: holds the divider sampled at the start
// of a transaction and counts down the idle cycles between two pulses.
module siso_shift_tick_gen
  import siso_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 latch_i,    // capture div_i (transaction start)
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 arm_i,      // a gap starts next cycle
  input  logic                 run_i,      // currently inside a gap
  output logic                 zero_div_o, // no gap: pulses back to back
  output logic                 gap_last_o  // this is the final gap cycle
);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // Next-state: latch divider on start, load counter on arm, count down in a gap.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (latch_i) begin
      div_d = div_i;
    end
    if (arm_i) begin
      cnt_d = div_q;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  // Register divider and gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign zero_div_o = (div_q == '0);
  assign gap_last_o = (cnt_q == DIV_WIDTH'(1));

endmodule

// File: rtl/siso_shift_controller.sv
// Sequencer for an external SISO shift chain: serialises Tx words MSB-first,
// captures the bits falling out of the chain as the Rx word (one-word delay
// line), and issues chain clear and flush operations.
module siso_shift_controller
  import siso_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CHAIN_LENGTH = DEF_CHAIN_LENGTH,
  parameter int DIV_WIDTH    = DEF_DIV_WIDTH
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic                  Enable_In,
  input  logic [DIV_WIDTH-1:0]  Clk_Div_In,
  input  logic [DATA_WIDTH-1:0] Tx_Data_In,
  input  logic                  Tx_Valid_In,
  output logic                  Tx_Ready_Out,
  input  logic                  Flush_In,
  input  logic                  Clear_In,
  output logic [DATA_WIDTH-1:0] Rx_Data_Out,
  output logic                  Rx_Valid_Out,
  input  logic                  Rx_Ready_In,
  output logic                  Busy_Out,
  output logic                  Abort_Out,
  output logic                  SISO_Reset_Out,
  output logic                  SISO_Enable_Out,
  output logic                  SISO_Shift_Out,
  output logic                  SISO_Serial_Data_Out,
  input  logic                  SISO_Serial_Data_In
);

  localparam int CNT_W = $clog2(max_int(DATA_WIDTH, CHAIN_LENGTH) + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  shift_q, shift_d;
  logic                  sdata_q, sdata_d;
  logic                  siso_en_q, siso_en_d;
  logic                  siso_rst_q, siso_rst_d;
  logic                  abort_q, abort_d;

  logic                  start_ok;
  logic                  tx_ready;
  logic                  enter_shift;
  logic [DATA_WIDTH-1:0] shift_src;
  logic                  latch_div;
  logic                  arm_gap;
  logic                  zero_div;
  logic                  gap_last;

  // A new operation may start only when enabled (also seen last cycle, which
  // keeps ready low throughout reset) and no captured word is still pending.
  assign start_ok = Enable_In && siso_en_q && !rx_valid_q;
  // Clear and flush outrank a Tx word, so ready drops while either is requested.
  assign tx_ready = (state_q == ST_IDLE) && start_ok && !Clear_In && !Flush_In;

  siso_shift_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clk        (Clk_In),
    .rst_n      (Reset_N_In),
    .latch_i    (latch_div),
    .div_i      (Clk_Div_In),
    .arm_i      (arm_gap),
    .run_i      (state_q == ST_GAP),
    .zero_div_o (zero_div),
    .gap_last_o (gap_last)
  );

  // Next-state and registered-output decode for the sequencer.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    shift_d     = 1'b0;
    sdata_d     = 1'b0;
    siso_en_d   = Enable_In;
    siso_rst_d  = 1'b0;
    abort_d     = 1'b0;
    enter_shift = 1'b0;
    shift_src   = tx_sr_q;
    latch_div   = 1'b0;
    arm_gap     = 1'b0;

    if (rx_valid_q && Rx_Ready_In) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (Clear_In) begin
          state_d    = ST_CLEAR;
          siso_rst_d = 1'b1;
        end else if (Flush_In && start_ok) begin
          shift_src   = '0;
          bit_cnt_d   = CNT_W'(CHAIN_LENGTH);
          latch_div   = 1'b1;
          enter_shift = 1'b1;
        end else if (Tx_Valid_In && tx_ready) begin
          shift_src   = Tx_Data_In;
          bit_cnt_d   = CNT_W'(DATA_WIDTH);
          latch_div   = 1'b1;
          enter_shift = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!Enable_In) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (bit_cnt_q == CNT_W'(1)) begin
          bit_cnt_d = '0;
          state_d   = ST_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          if (zero_div) begin
            enter_shift = 1'b1;
          end else begin
            state_d = ST_GAP;
            arm_gap = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (!Enable_In) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (gap_last) begin
          enter_shift = 1'b1;
        end
      end
      ST_DONE: begin
        rx_data_d  = rx_sr_q;
        rx_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering SHIFT: present the next MSB and capture the chain output as it
    // stands before this cycle's negedge shift.
    if (enter_shift) begin
      state_d = ST_SHIFT;
      shift_d = 1'b1;
      sdata_d = shift_src[DATA_WIDTH-1];
      tx_sr_d = {shift_src[DATA_WIDTH-2:0], 1'b0};
      rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], SISO_Serial_Data_In};
    end
  end

  // State and output registers; the chain is held in reset while we are.
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      shift_q    <= 1'b0;
      sdata_q    <= 1'b0;
      siso_en_q  <= 1'b0;
      siso_rst_q <= 1'b1;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      shift_q    <= shift_d;
      sdata_q    <= sdata_d;
      siso_en_q  <= siso_en_d;
      siso_rst_q <= siso_rst_d;
      abort_q    <= abort_d;
    end
  end

  assign Tx_Ready_Out         = tx_ready;
  assign Rx_Data_Out          = rx_data_q;
  assign Rx_Valid_Out         = rx_valid_q;
  assign Busy_Out             = (state_q != ST_IDLE);
  assign Abort_Out            = abort_q;
  assign SISO_Reset_Out       = siso_rst_q;
  assign SISO_Enable_Out      = siso_en_q;
  assign SISO_Shift_Out       = shift_q;
  assign SISO_Serial_Data_Out = sdata_q;

endmodule

// File: tb/tb_siso_shift_controller.sv
// Bench for siso_shift_controller: an 8-bit chain model sits on the SISO pins;
// the reference treats the chain as a one-word delay line.
module tb_siso_shift_controller;

  logic       clk = 1'b0;
  logic       Reset_N_In = 1'b1;
  logic       Enable_In = 1'b0;
  logic [7:0] Clk_Div_In = 8'd0;
  logic [7:0] Tx_Data_In = 8'd0;
  logic       Tx_Valid_In = 1'b0;
  logic       Tx_Ready_Out;
  logic       Flush_In = 1'b0;
  logic       Clear_In = 1'b0;
  logic [7:0] Rx_Data_Out;
  logic       Rx_Valid_Out;
  logic       Rx_Ready_In = 1'b0;
  logic       Busy_Out;
  logic       Abort_Out;
  logic       SISO_Reset_Out;
  logic       SISO_Enable_Out;
  logic       SISO_Shift_Out;
  logic       SISO_Serial_Data_Out;
  logic       SISO_Serial_Data_In;

  logic [7:0] chain = 8'hC3;
  logic [7:0] model_chain = 8'h00;
  int         edge_cnt = 0;
  int         acc_edge = 0;
  int         pulse_cyc[$];
  bit         pulse_dat[$];
  int         n_cmp = 0;
  int         n_err = 0;

  siso_shift_controller dut (
    .Clk_In               (clk),
    .Reset_N_In           (Reset_N_In),
    .Enable_In            (Enable_In),
    .Clk_Div_In           (Clk_Div_In),
    .Tx_Data_In           (Tx_Data_In),
    .Tx_Valid_In          (Tx_Valid_In),
    .Tx_Ready_Out         (Tx_Ready_Out),
    .Flush_In             (Flush_In),
    .Clear_In             (Clear_In),
    .Rx_Data_Out          (Rx_Data_Out),
    .Rx_Valid_Out         (Rx_Valid_Out),
    .Rx_Ready_In          (Rx_Ready_In),
    .Busy_Out             (Busy_Out),
    .Abort_Out            (Abort_Out),
    .SISO_Reset_Out       (SISO_Reset_Out),
    .SISO_Enable_Out      (SISO_Enable_Out),
    .SISO_Shift_Out       (SISO_Shift_Out),
    .SISO_Serial_Data_Out (SISO_Serial_Data_Out),
    .SISO_Serial_Data_In  (SISO_Serial_Data_In)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Attached chain: shifts on negedge, active-high reset; also logs each shift pulse
  // with its cycle number relative to the accept edge.
  always @(negedge clk) begin
    if (SISO_Shift_Out && SISO_Enable_Out) begin
      pulse_cyc.push_back(edge_cnt - acc_edge + 1);
      pulse_dat.push_back(SISO_Serial_Data_Out);
    end
    if (SISO_Reset_Out) chain <= 8'h00;
    else if (SISO_Enable_Out && SISO_Shift_Out) chain <= {chain[6:0], SISO_Serial_Data_Out};
  end
  assign SISO_Serial_Data_In = chain[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // One transfer (Tx word or flush): expected Rx is the previous chain word,
  // pulses every div+1 cycles, Rx valid at edge 1+(n-1)*(div+1)+1.
  task automatic run_xfer(input bit is_flush, input logic [7:0] word, input logic [7:0] div,
                          input int hold);
    logic [7:0] exp_rx;
    int exp_lat;
    int lat;
    bit got;
    bit exp_bit;
    exp_rx  = model_chain;
    exp_lat = 1 + 7 * (int'(div) + 1) + 1;
    Clk_Div_In = div;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (Tx_Ready_Out) begin got = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL tx_ready_wait: ready=%0b required=1", Tx_Ready_Out); end
    pulse_cyc.delete();
    pulse_dat.delete();
    if (is_flush) Flush_In = 1'b1;
    else begin Tx_Data_In = word; Tx_Valid_In = 1'b1; end
    @(posedge clk); #1;
    acc_edge = edge_cnt;
    Flush_In = 1'b0;
    Tx_Valid_In = 1'b0;
    Clk_Div_In = 8'($urandom);  // divider must have been sampled at accept
    got = 0;
    for (int i = 0; i < 2500; i++) begin
      if (Rx_Valid_Out) begin got = 1; break; end
      @(posedge clk); #1;
    end
    lat = edge_cnt - acc_edge;
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL rx_valid_wait: valid=%0b required=1", Rx_Valid_Out); end
    n_cmp++;
    if (lat !== exp_lat) begin n_err++; $display("FAIL rx_latency: got=%0d required=%0d", lat, exp_lat); end
    n_cmp++;
    if (Rx_Data_Out !== exp_rx) begin n_err++; $display("FAIL rx_data: got=%h required=%h", Rx_Data_Out, exp_rx); end
    n_cmp++;
    if (pulse_cyc.size() !== 8) begin n_err++; $display("FAIL pulse_count: got=%0d required=8", pulse_cyc.size()); end
    for (int i = 0; i < 8 && i < pulse_cyc.size(); i++) begin
      exp_bit = is_flush ? 1'b0 : word[7 - i];
      n_cmp++;
      if (pulse_dat[i] !== exp_bit) begin n_err++; $display("FAIL pulse_data[%0d]: got=%0b required=%0b", i, pulse_dat[i], exp_bit); end
      n_cmp++;
      if (pulse_cyc[i] !== 1 + i * (int'(div) + 1)) begin
        n_err++; $display("FAIL pulse_cycle[%0d]: got=%0d required=%0d", i, pulse_cyc[i], 1 + i * (int'(div) + 1));
      end
    end
    model_chain = is_flush ? 8'h00 : word;
    // Consumer stalls: word must stay put and no new Tx may be taken.
    Tx_Valid_In = (hold > 0);
    Tx_Data_In  = 8'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({Rx_Valid_Out, Rx_Data_Out, Tx_Ready_Out} !== {1'b1, exp_rx, 1'b0}) begin
        n_err++; $display("FAIL rx_hold: valid=%0b data=%h ready=%0b required 1/%h/0", Rx_Valid_Out, Rx_Data_Out, Tx_Ready_Out, exp_rx);
      end
    end
    Tx_Valid_In = 1'b0;
    Rx_Ready_In = 1'b1;
    @(posedge clk); #1;
    Rx_Ready_In = 1'b0;
    n_cmp++;
    if (Rx_Valid_Out !== 1'b0) begin n_err++; $display("FAIL rx_handshake: valid=%0b required=0", Rx_Valid_Out); end
    $display("xfer %s word=%h div=%0d hold=%0d rx_exp=%h latency=%0d", is_flush ? "flush" : "tx   ",
             word, div, hold, exp_rx, lat);
  endtask

  task automatic test_reset();
    #1 Reset_N_In = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({Busy_Out, Abort_Out, Rx_Valid_Out, Tx_Ready_Out, SISO_Enable_Out, SISO_Shift_Out,
         SISO_Serial_Data_Out, SISO_Reset_Out, Rx_Data_Out} !== {7'b0, 1'b1, 8'h00}) begin
      n_err++; $display("FAIL reset_outputs: busy=%0b abort=%0b rxv=%0b rdy=%0b en=%0b sh=%0b sd=%0b rst=%0b rx=%h required rst=1 rest 0",
        Busy_Out, Abort_Out, Rx_Valid_Out, Tx_Ready_Out, SISO_Enable_Out, SISO_Shift_Out,
        SISO_Serial_Data_Out, SISO_Reset_Out, Rx_Data_Out);
    end
    Reset_N_In = 1'b1;
    Enable_In  = 1'b1;
    model_chain = 8'h00;
    @(posedge clk); #1;
    n_cmp++;
    if (SISO_Reset_Out !== 1'b0) begin n_err++; $display("FAIL reset_release: siso_reset=%0b required=0", SISO_Reset_Out); end
    $display("reset checked");
  endtask

  task automatic test_basic();
    run_xfer(1'b0, 8'hA5, 8'd0, 0);
    run_xfer(1'b0, 8'h3C, 8'd0, 0);
    run_xfer(1'b1, 8'h00, 8'd0, 0);
  endtask

  task automatic test_divider();
    run_xfer(1'b0, 8'($urandom), 8'd3, 0);
  endtask

  task automatic test_rx_hold();
    run_xfer(1'b0, 8'($urandom), 8'd1, 5);
    run_xfer(1'b0, 8'($urandom), 8'd0, 0);
  endtask

  task automatic test_abort_clear();
    bit got;
    Clk_Div_In = 8'd2;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (Tx_Ready_Out) begin got = 1; break; end
      @(posedge clk); #1;
    end
    pulse_cyc.delete();
    pulse_dat.delete();
    Tx_Data_In = 8'($urandom);
    Tx_Valid_In = 1'b1;
    @(posedge clk); #1;
    acc_edge = edge_cnt;
    Tx_Valid_In = 1'b0;
    for (int i = 0; i < 50 && pulse_cyc.size() < 3; i++) begin @(posedge clk); #1; end
    Enable_In = 1'b0;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (Abort_Out) begin got = 1; break; end
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL abort_pulse: abort=%0b required=1", Abort_Out); end
    n_cmp++;
    if ({Busy_Out, Rx_Valid_Out} !== 2'b00) begin n_err++; $display("FAIL abort_state: busy=%0b rxv=%0b required 0/0", Busy_Out, Rx_Valid_Out); end
    @(posedge clk); #1;
    n_cmp++;
    if ({Abort_Out, Rx_Valid_Out} !== 2'b00) begin n_err++; $display("FAIL abort_one_cycle: abort=%0b rxv=%0b required 0/0", Abort_Out, Rx_Valid_Out); end
    n_cmp++;
    if (pulse_cyc.size() !== 3) begin n_err++; $display("FAIL abort_pulses: got=%0d required=3", pulse_cyc.size()); end
    $display("abort after %0d shifts", pulse_cyc.size());
    Enable_In = 1'b1;
    Clear_In = 1'b1;
    @(posedge clk); #1;
    Clear_In = 1'b0;
    n_cmp++;
    if ({SISO_Reset_Out, Busy_Out} !== 2'b11) begin n_err++; $display("FAIL clear_pulse: siso_reset=%0b busy=%0b required 1/1", SISO_Reset_Out, Busy_Out); end
    @(posedge clk); #1;
    n_cmp++;
    if ({SISO_Reset_Out, Busy_Out} !== 2'b00) begin n_err++; $display("FAIL clear_end: siso_reset=%0b busy=%0b required 0/0", SISO_Reset_Out, Busy_Out); end
    model_chain = 8'h00;
    run_xfer(1'b0, 8'($urandom), 8'd0, 0);
  endtask

  task automatic test_reset_mid_gap();
    Clk_Div_In = 8'd3;
    for (int i = 0; i < 50 && !Tx_Ready_Out; i++) begin @(posedge clk); #1; end
    Tx_Data_In = 8'($urandom);
    Tx_Valid_In = 1'b1;
    @(posedge clk); #1;
    Tx_Valid_In = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({Busy_Out, SISO_Shift_Out} !== 2'b10) begin n_err++; $display("FAIL gap_before_reset: busy=%0b shift=%0b required 1/0", Busy_Out, SISO_Shift_Out); end
    Reset_N_In = 1'b0;
    #1;
    n_cmp++;
    if ({Busy_Out, Abort_Out, Rx_Valid_Out, Tx_Ready_Out, SISO_Enable_Out, SISO_Shift_Out,
         SISO_Serial_Data_Out, SISO_Reset_Out, Rx_Data_Out} !== {7'b0, 1'b1, 8'h00}) begin
      n_err++; $display("FAIL async_reset: busy=%0b rxv=%0b rdy=%0b en=%0b rst=%0b rx=%h required rst=1 rest 0",
        Busy_Out, Rx_Valid_Out, Tx_Ready_Out, SISO_Enable_Out, SISO_Reset_Out, Rx_Data_Out);
    end
    repeat (2) @(posedge clk);
    #1 Reset_N_In = 1'b1;
    model_chain = 8'h00;
    $display("reset applied mid-gap");
    run_xfer(1'b0, 8'($urandom), 8'd0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      run_xfer(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_rx_hold();
    test_abort_clear();
    test_reset_mid_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
